// File: rtl/div_pkg.sv
// Shared constants and types for the iterative restoring divider.
package div_pkg;

    localparam int unsigned DIV_WIDTH   = 8;
    localparam int unsigned DIV_COUNT_W = 3;

    localparam logic [DIV_WIDTH-1:0] DIV_ZERO_QUOT = 8'hFF;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        FIN
    } div_state_t;

endpackage

// File: rtl/divider_if.sv
// START/BUSY/DONE handshake and operand/result bus of the divider.
interface divider_if;
    import div_pkg::*;

    logic                 start;
    logic [DIV_WIDTH-1:0] input1;
    logic [DIV_WIDTH-1:0] input2;
    logic [DIV_WIDTH-1:0] quotient;
    logic [DIV_WIDTH-1:0] remainder;
    logic                 busy;
    logic                 done;
    logic                 div_by_zero;

    modport master (
        output start, input1, input2,
        input  quotient, remainder, busy, done, div_by_zero
    );

    modport slave (
        input  start, input1, input2,
        output quotient, remainder, busy, done, div_by_zero
    );

endinterface

// File: rtl/div_step.sv
// One combinational restoring-division step: shift in a dividend bit, trial-subtract the divisor.
module div_step
    import div_pkg::*;
(
    input  logic [DIV_WIDTH-1:0] rem,
    input  logic                 dividend_msb,
    input  logic [DIV_WIDTH-1:0] divisor,
    output logic [DIV_WIDTH-1:0] rem_next,
    output logic                 quot_bit
);

    logic [DIV_WIDTH:0]   shifted;
    logic [DIV_WIDTH+1:0] trial;
    logic                 unused_hi;

    // Extra top bit of trial is the borrow, i.e. the sign of (shifted - divisor).
    assign shifted  = {rem, dividend_msb};
    assign trial    = {1'b0, shifted} - {2'b00, divisor};
    assign quot_bit = ~trial[DIV_WIDTH+1];

    // Either candidate is below the divisor, so its top bit is always zero.
    assign rem_next  = quot_bit ? trial[DIV_WIDTH-1:0] : shifted[DIV_WIDTH-1:0];
    assign unused_hi = trial[DIV_WIDTH] ^ shifted[DIV_WIDTH];

endmodule

// File: rtl/divider.sv
// Iterative 8-bit restoring divider (9-cycle latency, 1 cycle on divide by zero).
// Define DIVIDER_SIGNED_EN for two's complement operands with truncation toward zero.
module divider
    import div_pkg::*;
(
    input  logic    clk,
    input  logic    reset,
    divider_if.slave bus
);

    localparam logic [DIV_COUNT_W-1:0] LastCount = DIV_COUNT_W'(DIV_WIDTH - 1);

    div_state_t             state_q, state_d;
    logic [DIV_COUNT_W-1:0] count_q, count_d;
    logic [DIV_WIDTH-1:0]   rem_q, rem_d;
    logic [DIV_WIDTH-1:0]   dvd_q, dvd_d;
    logic [DIV_WIDTH-1:0]   dsr_q, dsr_d;
    logic                   zero_q, zero_d;
    logic [DIV_WIDTH-1:0]   quot_q, quot_d;
    logic [DIV_WIDTH-1:0]   remo_q, remo_d;
    logic                   dbz_q, dbz_d;
    logic                   done_q, done_d;

    logic [DIV_WIDTH-1:0]   in1_mag, in2_mag;
    logic [DIV_WIDTH-1:0]   fix_quot, fix_rem;
    logic [DIV_WIDTH-1:0]   step_rem;
    logic                   step_bit;

`ifdef DIVIDER_SIGNED_EN
    logic neg_quot_q, neg_quot_d;
    logic neg_rem_q, neg_rem_d;

    assign in1_mag  = bus.input1[DIV_WIDTH-1] ? ({DIV_WIDTH{1'b0}} - bus.input1) : bus.input1;
    assign in2_mag  = bus.input2[DIV_WIDTH-1] ? ({DIV_WIDTH{1'b0}} - bus.input2) : bus.input2;
    // Quotient negative when signs differ; remainder follows the dividend.
    assign fix_quot = neg_quot_q ? ({DIV_WIDTH{1'b0}} - dvd_q) : dvd_q;
    assign fix_rem  = neg_rem_q ? ({DIV_WIDTH{1'b0}} - rem_q) : rem_q;
`else
    assign in1_mag  = bus.input1;
    assign in2_mag  = bus.input2;
    assign fix_quot = dvd_q;
    assign fix_rem  = rem_q;
`endif

    div_step u_step (
        .rem          (rem_q),
        .dividend_msb (dvd_q[DIV_WIDTH-1]),
        .divisor      (dsr_q),
        .rem_next     (step_rem),
        .quot_bit     (step_bit)
    );

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        rem_d   = rem_q;
        dvd_d   = dvd_q;
        dsr_d   = dsr_q;
        zero_d  = zero_q;
        quot_d  = quot_q;
        remo_d  = remo_q;
        dbz_d   = dbz_q;
        done_d  = 1'b0;
`ifdef DIVIDER_SIGNED_EN
        neg_quot_d = neg_quot_q;
        neg_rem_d  = neg_rem_q;
`endif

        unique case (state_q)
            IDLE: begin
                if (bus.start) begin
                    if (bus.input2 == '0) begin
                        // Raw dividend is reported as the remainder, even in signed mode.
                        dvd_d   = bus.input1;
                        zero_d  = 1'b1;
                        state_d = FIN;
                    end else begin
                        dvd_d   = in1_mag;
                        dsr_d   = in2_mag;
                        rem_d   = '0;
                        count_d = '0;
                        zero_d  = 1'b0;
                        state_d = CALC;
`ifdef DIVIDER_SIGNED_EN
                        neg_quot_d = bus.input1[DIV_WIDTH-1] ^ bus.input2[DIV_WIDTH-1];
                        neg_rem_d  = bus.input1[DIV_WIDTH-1];
`endif
                    end
                end
            end
            CALC: begin
                // Quotient bits shift into the vacated low end of the dividend register.
                rem_d   = step_rem;
                dvd_d   = {dvd_q[DIV_WIDTH-2:0], step_bit};
                count_d = count_q + DIV_COUNT_W'(1);
                if (count_q == LastCount) begin
                    state_d = FIN;
                end
            end
            FIN: begin
                done_d  = 1'b1;
                state_d = IDLE;
                if (zero_q) begin
                    quot_d = DIV_ZERO_QUOT;
                    remo_d = dvd_q;
                    dbz_d  = 1'b1;
                end else begin
                    quot_d = fix_quot;
                    remo_d = fix_rem;
                    dbz_d  = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            count_q <= '0;
            rem_q   <= '0;
            dvd_q   <= '0;
            dsr_q   <= '0;
            zero_q  <= 1'b0;
            quot_q  <= '0;
            remo_q  <= '0;
            dbz_q   <= 1'b0;
            done_q  <= 1'b0;
`ifdef DIVIDER_SIGNED_EN
            neg_quot_q <= 1'b0;
            neg_rem_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            rem_q   <= rem_d;
            dvd_q   <= dvd_d;
            dsr_q   <= dsr_d;
            zero_q  <= zero_d;
            quot_q  <= quot_d;
            remo_q  <= remo_d;
            dbz_q   <= dbz_d;
            done_q  <= done_d;
`ifdef DIVIDER_SIGNED_EN
            neg_quot_q <= neg_quot_d;
            neg_rem_q  <= neg_rem_d;
`endif
        end
    end

    assign bus.busy        = (state_q != IDLE);
    assign bus.done        = done_q;
    assign bus.quotient    = quot_q;
    assign bus.remainder   = remo_q;
    assign bus.div_by_zero = dbz_q;

endmodule
